// File: rtl/riscv_dmem_arbiter.sv
// Round-robin arbiter sharing the single-port data memory between the core LSU (m0) and debug/DMA (m1).
// Grants are combinational; read data is registered one cycle after the grant; a bounded lock supports atomic RMW.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef DMEM_ADDR_BIT
`define DMEM_ADDR_BIT 12
`endif

module riscv_dmem_arbiter #(
  parameter int MAX_LOCK = 8,
  parameter int XLEN     = `XLEN,
  parameter int AW       = `DMEM_ADDR_BIT - 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_m0_req,
  input  logic              i_m0_wr,
  input  logic              i_m0_lock,
  input  logic [AW-1:0]     i_m0_addr,
  input  logic [XLEN-1:0]   i_m0_wdata,
  input  logic [XLEN/8-1:0] i_m0_byte_sel,
  output logic              o_m0_gnt,
  output logic              o_m0_rvalid,
  output logic [XLEN-1:0]   o_m0_rdata,
  input  logic              i_m1_req,
  input  logic              i_m1_wr,
  input  logic              i_m1_lock,
  input  logic [AW-1:0]     i_m1_addr,
  input  logic [XLEN-1:0]   i_m1_wdata,
  input  logic [XLEN/8-1:0] i_m1_byte_sel,
  output logic              o_m1_gnt,
  output logic              o_m1_rvalid,
  output logic [XLEN-1:0]   o_m1_rdata,
  output logic [XLEN-1:0]   o_dmem_data,
  output logic [AW-1:0]     o_dmem_addr,
  output logic [XLEN/8-1:0] o_dmem_byte_sel,
  output logic              o_dmem_wr_en,
  input  logic [XLEN-1:0]   i_dmem_data
);

  localparam int CW = $clog2(MAX_LOCK + 1);
  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  logic [0:0]    st;
  logic          owner;
  logic          last;
  logic [CW-1:0] lock_cnt;

  logic hold, gnt0, gnt1, any_gnt, sel, sel_wr, sel_lock;

  // A lock only blocks the other master while the owner is still asking.
  always_comb begin
    hold = (st == ST_LOCKED) && (owner ? i_m1_req : i_m0_req);
    if (hold) begin
      gnt0 = ~owner;
      gnt1 = owner;
    end else begin
      gnt0 = i_m0_req && (!i_m1_req || last);
      gnt1 = i_m1_req && (!i_m0_req || !last);
    end
    any_gnt  = gnt0 | gnt1;
    sel      = gnt1;
    sel_wr   = sel ? i_m1_wr   : i_m0_wr;
    sel_lock = sel ? i_m1_lock : i_m0_lock;
  end

  assign o_m0_gnt = gnt0;
  assign o_m1_gnt = gnt1;

  always_comb begin
    o_dmem_addr     = '0;
    o_dmem_data     = '0;
    o_dmem_byte_sel = '0;
    o_dmem_wr_en    = 1'b0;
    if (any_gnt) begin
      o_dmem_addr  = sel ? i_m1_addr  : i_m0_addr;
      o_dmem_data  = sel ? i_m1_wdata : i_m0_wdata;
      o_dmem_wr_en = sel_wr;
      if (sel_wr) o_dmem_byte_sel = sel ? i_m1_byte_sel : i_m0_byte_sel;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      st          <= ST_IDLE;
      owner       <= 1'b0;
      last        <= 1'b1;
      lock_cnt    <= '0;
      o_m0_rvalid <= 1'b0;
      o_m1_rvalid <= 1'b0;
      o_m0_rdata  <= '0;
      o_m1_rdata  <= '0;
    end else begin
      if (any_gnt) last <= sel;
      o_m0_rvalid <= gnt0 & ~i_m0_wr;
      o_m1_rvalid <= gnt1 & ~i_m1_wr;
      if (gnt0 && !i_m0_wr) o_m0_rdata <= i_dmem_data;
      if (gnt1 && !i_m1_wr) o_m1_rdata <= i_dmem_data;
      case (st)
        ST_IDLE: begin
          if (any_gnt && sel_lock && MAX_LOCK > 1) begin
            st       <= ST_LOCKED;
            owner    <= sel;
            lock_cnt <= CW'(1);
          end
        end
        ST_LOCKED: begin
          // Forced release leaves last=owner, so the other master wins the next contest.
          if (hold && sel_lock && lock_cnt != CW'(MAX_LOCK - 1)) begin
            lock_cnt <= lock_cnt + CW'(1);
          end else begin
            st       <= ST_IDLE;
            lock_cnt <= '0;
          end
        end
        default: begin
          st       <= ST_IDLE;
          lock_cnt <= '0;
        end
      endcase
    end
  end

endmodule
